// File: rtl/input_channel_queue_if.sv
// Handshake bundle between an upstream enqueueing unit, the input channel queue
// and the consuming PE logic.
interface input_channel_queue_if #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  enqueue;
    logic [WORD_WIDTH-1:0] input_word;
    logic [TAG_WIDTH-1:0]  input_tag;
    logic                  dequeue;
    logic                  full;
    logic                  head_valid;
    logic [WORD_WIDTH-1:0] head_word;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic [CW-1:0]         count;
    logic                  error;

    modport master (
        output enqueue, input_word, input_tag, dequeue,
        input  full, head_valid, head_word, head_tag, count, error
    );

    modport slave (
        input  enqueue, input_word, input_tag, dequeue,
        output full, head_valid, head_word, head_tag, count, error
    );
endinterface

// File: rtl/input_channel_queue.sv
// Receive-side FIFO for one tagged input channel: buffers word/tag pairs and
// exposes the head entry to trigger resolution, with a sticky protocol error.
module input_channel_queue #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
) (
    input  logic clock,
    input  logic reset,
    input_channel_queue_if.slave q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_WIDTH-1:0] word_q [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  error_q, error_d;
    logic                  full, head_valid, push, pop;

    // Status depends only on registered occupancy, never on this cycle's requests.
    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);

    always_comb begin
        push     = q_if.enqueue && (!full || q_if.dequeue);
        pop      = q_if.dequeue && head_valid;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        error_d  = error_q
                 | (q_if.dequeue && !head_valid)
                 | (q_if.enqueue && full && !q_if.dequeue);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            if (push) begin
                word_q[wr_ptr_q] <= q_if.input_word;
                tag_q[wr_ptr_q]  <= q_if.input_tag;
            end
        end
    end

    assign q_if.full       = full;
    assign q_if.head_valid = head_valid;
    assign q_if.head_word  = head_valid ? word_q[rd_ptr_q] : '0;
    assign q_if.head_tag   = head_valid ? tag_q[rd_ptr_q]  : '0;
    assign q_if.count      = count_q;
    assign q_if.error      = error_q;
endmodule
